branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Frontend branch predictor.
- Looks up a prediction (taken, target) for each fetched PC; the prediction travels with the instruction to the branch unit.
- Consumes the branch unit's resolution stream to train a 2-bit-counter BHT and a direct-mapped BTB.
- On a reported misprediction, issues a one-cycle flush plus redirect PC to the fetch stage.

Parameters:
XLEN, 32, datapath/PC width (from mmm_pkg)
BHT_IDX_LEN, 6, log2 of BHT entries (64 x 2-bit saturating counters)
BTB_IDX_LEN, 5, log2 of BTB entries (32 x {valid, tag, target})

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
fetch_valid_i  in  1  fetch_pc_i valid this cycle
fetch_pc_i  in  XLEN  PC to predict
pred_valid_o  out  1  prediction valid (1 cycle after fetch)
pred_pc_o  out  XLEN  PC the prediction belongs to
pred_taken_o  out  1  predicted direction
pred_target_o  out  XLEN  predicted next PC
res_valid_i  in  1  resolution valid from branch unit
res_pc_i  in  XLEN  resolved branch PC
res_target_i  in  XLEN  computed taken target
res_taken_i  in  1  actual direction
res_mispredict_i  in  1  prediction was wrong (direction or target)
flush_o  out  1  one-cycle pulse: squash frontend
redirect_pc_o  out  XLEN  correct next PC, valid while flush_o=1

Behaviour:
- Clock clk_i; reset rst_n_i asynchronous, active-low.
- Reset values:
  - All outputs 0.
  - All BTB valid bits 0.
  - All BHT counters 2'b01 (weakly not-taken).
  - GHR (if present) 0.
  - BTB tag/target arrays need no reset.
- Indexing:
  - BTB index = pc[BTB_IDX_LEN+1:2].
  - BTB tag = pc[XLEN-1:BTB_IDX_LEN+2].
  - BHT index = pc[BHT_IDX_LEN+1:2] (see optional feature). pc[1:0] ignored.
- Lookup, latency 1:
  - If fetch_valid_i in cycle t, then in t+1: pred_valid_o=1, pred_pc_o=fetch_pc_i.
  - hit = BTB valid && tag match.
  - pred_taken_o = hit && counter[1].
  - pred_target_o = pred_taken_o ? BTB target : fetch_pc_i+4 (mod 2^XLEN).
  - If fetch_valid_i=0: pred_valid_o=0 in t+1; other pred outputs hold.
- Update, on res_valid_i in cycle t, tables written at edge ending t:
  - BHT counter: res_taken_i -> saturating increment (11 stays 11); else saturating decrement (00 stays 00).
  - If res_taken_i: BTB entry <= {valid=1, tag(res_pc_i), res_target_i}; overwrites any alias.
  - If !res_taken_i: BTB unchanged.
- Redirect:
  - If res_valid_i && res_mispredict_i in t: flush_o=1 in t+1 for exactly one cycle.
  - redirect_pc_o = res_taken_i ? res_target_i : res_pc_i+4.
  - Otherwise flush_o=0 and redirect_pc_o holds.
- res_mispredict_i ignored when res_valid_i=0.
- Simultaneous lookup and update to same entry in the same cycle: lookup returns pre-update contents (read-before-write).
- Flush priority: when flush_o=1 in cycle t+1, pred_valid_o is forced 0 in that cycle (the in-flight lookup is wrong-path).
- No backpressure: one lookup and one update accepted every cycle; no ready signals.
- Reset asserted mid-operation: all state returns to reset values immediately; a pending flush is dropped.

Optional Feature:
- Macro: BRANCH_PREDICTOR_GSHARE_EN.
- Defined:
  - Adds a BHT_IDX_LEN-bit global history register (GHR), reset 0.
  - On each res_valid_i, GHR <= {GHR[BHT_IDX_LEN-2:0], res_taken_i} (non-speculative).
  - BHT index for both lookup and update = pc[BHT_IDX_LEN+1:2] XOR GHR.
  - Lookup uses the GHR value before that cycle's update.
  - BTB indexing unchanged.
- Undefined: no GHR; bimodal indexing by PC bits only.

Test Plan:
- Reset, then fetch_pc_i=0x100 -> next cycle pred_valid_o=1, pred_taken_o=0, pred_target_o=0x104; flush_o=0.
- Resolve pc=0x100, taken, target=0x200, mispredict=1 twice (counter 01->10->11) -> each following cycle flush_o=1 with redirect_pc_o=0x200; afterwards fetch 0x100 gives pred_taken_o=1, pred_target_o=0x200.
- Resolve 0x100 not-taken, mispredict=1 three times from counter 11 -> redirect_pc_o=0x104; counter saturates at 00; BTB entry still valid; fetch 0x100 gives pred_taken_o=0, pred_target_o=0x104.
- Alias: train 0x100 taken->0x200, then resolve 0x180 (same BTB index, different tag) taken->0x300 -> fetch 0x100 misses (pred_taken_o=0, target 0x104); fetch 0x180 predicts 0x300.
- Same-cycle fetch 0x100 and resolve 0x100 taken (first time) -> prediction shows old state (not taken); next fetch of 0x100 sees the updated state; flush cycle forces pred_valid_o=0.
- With BRANCH_PREDICTOR_GSHARE_EN: resolve alternating T/N pattern at 0x100 for 20 iterations -> mispredict rate reaches 0 in the final 8. Without the macro, the same pattern keeps mispredicting.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/prediction/resolution/redirect bundle between the frontend, the predictor and the branch unit.
// The slave modport is the predictor's view; master is the frontend/branch-unit side.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic            fetch_valid_i;
  logic [XLEN-1:0] fetch_pc_i;

  logic            pred_valid_o;
  logic [XLEN-1:0] pred_pc_o;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_target_o;

  logic            res_valid_i;
  logic [XLEN-1:0] res_pc_i;
  logic [XLEN-1:0] res_target_i;
  logic            res_taken_i;
  logic            res_mispredict_i;

  logic            flush_o;
  logic [XLEN-1:0] redirect_pc_o;

  modport slave (
    input  fetch_valid_i, fetch_pc_i,
    input  res_valid_i, res_pc_i, res_target_i, res_taken_i, res_mispredict_i,
    output pred_valid_o, pred_pc_o, pred_taken_o, pred_target_o,
    output flush_o, redirect_pc_o
  );

  modport master (
    output fetch_valid_i, fetch_pc_i,
    output res_valid_i, res_pc_i, res_target_i, res_taken_i, res_mispredict_i,
    input  pred_valid_o, pred_pc_o, pred_taken_o, pred_target_o,
    input  flush_o, redirect_pc_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal 2-bit-counter BHT plus direct-mapped BTB with one-cycle lookup and misprediction redirect.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR a non-speculative global history register into the BHT index.
module branch_predictor #(
  parameter int XLEN        = 32,
  parameter int BHT_IDX_LEN = 6,
  parameter int BTB_IDX_LEN = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  branch_predictor_if.slave bp_if
);

  localparam int BHT_N = 1 << BHT_IDX_LEN;
  localparam int BTB_N = 1 << BTB_IDX_LEN;
  localparam int TAG_W = XLEN - BTB_IDX_LEN - 2;

  // Tables
  logic [1:0]       bht_q        [BHT_N];
  logic [BTB_N-1:0] btb_valid_q;
  logic [TAG_W-1:0] btb_tag_q    [BTB_N];
  logic [XLEN-1:0]  btb_target_q [BTB_N];

  // Registered outputs
  logic            pred_valid_q,  pred_valid_d;
  logic [XLEN-1:0] pred_pc_q,     pred_pc_d;
  logic            pred_taken_q,  pred_taken_d;
  logic [XLEN-1:0] pred_target_q, pred_target_d;
  logic            flush_q,       flush_d;
  logic [XLEN-1:0] redirect_q,    redirect_d;

  logic [BHT_IDX_LEN-1:0] lk_bht_idx;
  logic [BHT_IDX_LEN-1:0] up_bht_idx;
  logic [BTB_IDX_LEN-1:0] lk_btb_idx;
  logic [BTB_IDX_LEN-1:0] up_btb_idx;
  logic [TAG_W-1:0]       lk_tag;
  logic [TAG_W-1:0]       up_tag;
  logic                   lk_hit;
  logic                   lk_taken;
  logic [1:0]             up_ctr_cur;
  logic [1:0]             up_ctr_new;
  logic                   bht_we;
  logic                   btb_we;

  assign lk_btb_idx = bp_if.fetch_pc_i[BTB_IDX_LEN+1:2];
  assign up_btb_idx = bp_if.res_pc_i[BTB_IDX_LEN+1:2];
  assign lk_tag     = bp_if.fetch_pc_i[XLEN-1:BTB_IDX_LEN+2];
  assign up_tag     = bp_if.res_pc_i[XLEN-1:BTB_IDX_LEN+2];

  assign bht_we = bp_if.res_valid_i;
  assign btb_we = bp_if.res_valid_i && bp_if.res_taken_i;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [BHT_IDX_LEN-1:0] ghr_q, ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (bp_if.res_valid_i) begin
      ghr_d = {ghr_q[BHT_IDX_LEN-2:0], bp_if.res_taken_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  // Both lookup and update hash with the history as it stood before this cycle's resolution.
  assign lk_bht_idx = bp_if.fetch_pc_i[BHT_IDX_LEN+1:2] ^ ghr_q;
  assign up_bht_idx = bp_if.res_pc_i[BHT_IDX_LEN+1:2] ^ ghr_q;
`else
  assign lk_bht_idx = bp_if.fetch_pc_i[BHT_IDX_LEN+1:2];
  assign up_bht_idx = bp_if.res_pc_i[BHT_IDX_LEN+1:2];
`endif

  // Lookup reads the tables combinationally, so a same-cycle update is only seen next cycle.
  assign lk_hit   = btb_valid_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == lk_tag);
  assign lk_taken = lk_hit && bht_q[lk_bht_idx][1];

  assign up_ctr_cur = bht_q[up_bht_idx];

  always_comb begin
    up_ctr_new = up_ctr_cur;
    if (bp_if.res_taken_i) begin
      if (up_ctr_cur != 2'b11) begin
        up_ctr_new = up_ctr_cur + 2'b01;
      end
    end else begin
      if (up_ctr_cur != 2'b00) begin
        up_ctr_new = up_ctr_cur - 2'b01;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < BHT_N; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (bht_we) begin
      bht_q[up_bht_idx] <= up_ctr_new;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      btb_valid_q <= '0;
    end else if (btb_we) begin
      btb_valid_q[up_btb_idx] <= 1'b1;
    end
  end

  // Tag/target storage is only meaningful behind a valid bit, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (btb_we) begin
      btb_tag_q[up_btb_idx]    <= up_tag;
      btb_target_q[up_btb_idx] <= bp_if.res_target_i;
    end
  end

  always_comb begin
    flush_d    = bp_if.res_valid_i && bp_if.res_mispredict_i;
    redirect_d = redirect_q;
    if (flush_d) begin
      redirect_d = bp_if.res_taken_i ? bp_if.res_target_i
                                     : bp_if.res_pc_i + XLEN'(4);
    end
  end

  always_comb begin
    // A flush in the next cycle squashes the lookup issued now as wrong-path.
    pred_valid_d  = bp_if.fetch_valid_i && !flush_d;
    pred_pc_d     = pred_pc_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (bp_if.fetch_valid_i) begin
      pred_pc_d     = bp_if.fetch_pc_i;
      pred_taken_d  = lk_taken;
      pred_target_d = lk_taken ? btb_target_q[lk_btb_idx]
                               : bp_if.fetch_pc_i + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pred_valid_q  <= 1'b0;
      pred_pc_q     <= '0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      flush_q       <= 1'b0;
      redirect_q    <= '0;
    end else begin
      pred_valid_q  <= pred_valid_d;
      pred_pc_q     <= pred_pc_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
    end
  end

  assign bp_if.pred_valid_o  = pred_valid_q;
  assign bp_if.pred_pc_o     = pred_pc_q;
  assign bp_if.pred_taken_o  = pred_taken_q;
  assign bp_if.pred_target_o = pred_target_q;
  assign bp_if.flush_o       = flush_q;
  assign bp_if.redirect_pc_o = redirect_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor; expected values are hand-derived from the counter/BTB rules.
`timescale 1ns/1ps
module tb_branch_predictor;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  branch_predictor_if #(.XLEN(32)) bus ();

  branch_predictor #(
    .XLEN       (32),
    .BHT_IDX_LEN(6),
    .BTB_IDX_LEN(5)
  ) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .bp_if  (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic clear_inputs();
    bus.fetch_valid_i    = 1'b0;
    bus.fetch_pc_i       = '0;
    bus.res_valid_i      = 1'b0;
    bus.res_pc_i         = '0;
    bus.res_target_i     = '0;
    bus.res_taken_i      = 1'b0;
    bus.res_mispredict_i = 1'b0;
  endtask

  // Apply one cycle of stimulus, step past the edge, and leave the inputs idle.
  task automatic cycle(input logic fv, input logic [31:0] fpc,
                       input logic rv, input logic [31:0] rpc, input logic [31:0] rtgt,
                       input logic rtk, input logic rmis);
    bus.fetch_valid_i    = fv;
    bus.fetch_pc_i       = fpc;
    bus.res_valid_i      = rv;
    bus.res_pc_i         = rpc;
    bus.res_target_i     = rtgt;
    bus.res_taken_i      = rtk;
    bus.res_mispredict_i = rmis;
    @(posedge clk_i);
    #1;
    clear_inputs();
  endtask

  task automatic fetch(input logic [31:0] pc);
    cycle(1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic mis);
    cycle(1'b0, 32'h0, 1'b1, pc, tgt, tk, mis);
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic check_pred(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    check_val({tag, ".valid"},  {31'h0, bus.pred_valid_o}, 32'h1);
    check_val({tag, ".pc"},     bus.pred_pc_o, pc);
    check_val({tag, ".taken"},  {31'h0, bus.pred_taken_o}, {31'h0, tk});
    check_val({tag, ".target"}, bus.pred_target_o, tgt);
  endtask

  int   miss_last8;
  logic act;
  logic exp_p;

  initial begin
    clear_inputs();
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_val("rst.pred_valid",  {31'h0, bus.pred_valid_o}, 32'h0);
    check_val("rst.pred_taken",  {31'h0, bus.pred_taken_o}, 32'h0);
    check_val("rst.pred_target", bus.pred_target_o, 32'h0);
    check_val("rst.flush",       {31'h0, bus.flush_o}, 32'h0);
    check_val("rst.redirect",    bus.redirect_pc_o, 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    fetch(32'h100);
    check_pred("cold", 32'h100, 1'b0, 32'h104);
    check_val("cold.flush", {31'h0, bus.flush_o}, 32'h0);
    idle();
    check_val("idle.pred_valid", {31'h0, bus.pred_valid_o}, 32'h0);
    check_val("idle.pred_pc_hold", bus.pred_pc_o, 32'h100);

`ifndef BRANCH_PREDICTOR_GSHARE_EN
    // Counter 01 -> 10 -> 11, each with a redirect to the taken target.
    for (int k = 0; k < 2; k++) begin
      resolve(32'h100, 32'h200, 1'b1, 1'b1);
      check_val("train_t.flush",    {31'h0, bus.flush_o}, 32'h1);
      check_val("train_t.redirect", bus.redirect_pc_o, 32'h200);
      idle();
      check_val("train_t.flush_off", {31'h0, bus.flush_o}, 32'h0);
    end
    fetch(32'h100);
    check_pred("trained", 32'h100, 1'b1, 32'h200);

    // Counter 11 -> 10 -> 01 -> 00 (saturated).
    for (int k = 0; k < 3; k++) begin
      resolve(32'h100, 32'h200, 1'b0, 1'b1);
      check_val("train_n.flush",    {31'h0, bus.flush_o}, 32'h1);
      check_val("train_n.redirect", bus.redirect_pc_o, 32'h104);
      idle();
    end
    fetch(32'h100);
    check_pred("untrained", 32'h100, 1'b0, 32'h104);
    // From a saturated 00 one taken only reaches 01, still not-taken.
    resolve(32'h100, 32'h200, 1'b1, 1'b0);
    check_val("sat.no_flush", {31'h0, bus.flush_o}, 32'h0);
    fetch(32'h100);
    check_pred("sat00", 32'h100, 1'b0, 32'h104);

    // 01 -> 10 -> 11, then 0x180 aliases BTB slot 0 with a different tag.
    resolve(32'h100, 32'h200, 1'b1, 1'b0);
    resolve(32'h100, 32'h200, 1'b1, 1'b0);
    fetch(32'h100);
    check_pred("pre_alias", 32'h100, 1'b1, 32'h200);
    resolve(32'h180, 32'h300, 1'b1, 1'b0);
    fetch(32'h100);
    check_pred("alias_miss", 32'h100, 1'b0, 32'h104);
    fetch(32'h180);
    check_pred("alias_hit", 32'h180, 1'b1, 32'h300);

    // Same-cycle lookup and update of a fresh entry sees the old contents.
    cycle(1'b1, 32'h208, 1'b1, 32'h208, 32'h500, 1'b1, 1'b0);
    check_pred("rbw_old", 32'h208, 1'b0, 32'h20C);
    fetch(32'h208);
    check_pred("rbw_new", 32'h208, 1'b1, 32'h500);

    // A flush squashes the lookup issued in the same cycle as the mispredict.
    cycle(1'b1, 32'h100, 1'b1, 32'h208, 32'h500, 1'b1, 1'b1);
    check_val("flushprio.pred_valid", {31'h0, bus.pred_valid_o}, 32'h0);
    check_val("flushprio.flush",      {31'h0, bus.flush_o}, 32'h1);
    check_val("flushprio.redirect",   bus.redirect_pc_o, 32'h500);
    idle();
    check_val("after_flush.flush",    {31'h0, bus.flush_o}, 32'h0);
    check_val("after_flush.redirect", bus.redirect_pc_o, 32'h500);
`endif

    // Reset in the middle of a pending flush drops it immediately.
    resolve(32'h100, 32'h200, 1'b0, 1'b1);
    check_val("midrst.flush_before", {31'h0, bus.flush_o}, 32'h1);
    rst_n_i = 1'b0;
    #1;
    check_val("midrst.flush",    {31'h0, bus.flush_o}, 32'h0);
    check_val("midrst.redirect", bus.redirect_pc_o, 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_val("midrst.flush_after", {31'h0, bus.flush_o}, 32'h0);
    fetch(32'h100);
    check_pred("midrst.cold", 32'h100, 1'b0, 32'h104);

    // Alternating T/N at 0x100 from a cold table.
    miss_last8 = 0;
    for (int i = 0; i < 20; i++) begin
      act = (i % 2 == 0);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
      exp_p = (i >= 8) ? act : 1'b0;
`else
      exp_p = (i % 2 == 1);
`endif
      fetch(32'h100);
      check_val($sformatf("alt%0d.taken", i), {31'h0, bus.pred_taken_o}, {31'h0, exp_p});
      if (i >= 12 && bus.pred_taken_o != act) miss_last8++;
      resolve(32'h100, 32'h200, act, exp_p != act);
      check_val($sformatf("alt%0d.flush", i), {31'h0, bus.flush_o}, {31'h0, exp_p != act});
    end
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    check_val("alt.miss_last8", miss_last8, 32'd0);
`else
    check_val("alt.miss_last8", miss_last8, 32'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion, expected $finish");
    $fatal(1);
  end

endmodule
